alto_shift_unit: RTL



---
 rtl/alto_shift_unit_pkg.sv | 36 +++
 rtl/alto_shifter.sv | 41 ++++
 rtl/alto_shift_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alto_shift_unit_pkg.sv
// Shared encodings for the shift unit: shifter functions, Nova carry base
// operations and Nova skip conditions.
package alto_shift_unit_pkg;

  localparam int unsigned DataWidth = 16;

  typedef enum logic [2:0] {
    ShNone = 3'd0,
    ShLsh1 = 3'd1,
    ShRsh1 = 3'd2,
    ShLcy8 = 3'd3,
    ShMlsh = 3'd4,
    ShMrsh = 3'd5,
    ShNlcy = 3'd6,
    ShNrcy = 3'd7
  } sh_op_e;

  typedef enum logic [1:0] {
    CyKeep = 2'd0,
    CyZero = 2'd1,
    CyOne  = 2'd2,
    CyCmpl = 2'd3
  } cy_op_e;

  typedef enum logic [2:0] {
    SkipNever  = 3'd0,
    SkipAlways = 3'd1,
    SkipSzc    = 3'd2,
    SkipSnc    = 3'd3,
    SkipSzr    = 3'd4,
    SkipSnr    = 3'd5,
    SkipSez    = 3'd6,
    SkipSbn    = 3'd7
  } skip_e;

endpackage

// File: rtl/alto_shifter.sv
// Combinational shifter between L/T and the bus.
//   l_i, t_i  : L and T register values
//   op_i      : shifter function
//   cin_i     : effective Nova carry-in
//   result_o  : shifted value
//   carry_o   : new Nova carry (bit rotated out for NLCY/NRCY, else cin_i)
module alto_shifter
  import alto_shift_unit_pkg::*;
(
  input  logic [DataWidth-1:0] l_i,
  input  logic [DataWidth-1:0] t_i,
  input  sh_op_e               op_i,
  input  logic                 cin_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 carry_o
);

  always_comb begin
    result_o = l_i;
    carry_o  = cin_i;
    unique case (op_i)
      ShNone: result_o = l_i;
      ShLsh1: result_o = {l_i[14:0], 1'b0};
      ShRsh1: result_o = {1'b0, l_i[15:1]};
      ShLcy8: result_o = {l_i[7:0], l_i[15:8]};
      ShMlsh: result_o = {l_i[14:0], t_i[15]};
      ShMrsh: result_o = {t_i[0], l_i[15:1]};
      // 17-bit rotates through the carry
      ShNlcy: begin
        result_o = {l_i[14:0], cin_i};
        carry_o  = l_i[15];
      end
      ShNrcy: begin
        result_o = {cin_i, l_i[15:1]};
        carry_o  = l_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alto_shift_unit.sv
// Datapath stage after the ALU: holds L, ALUC0, T, the Nova carry and the
// registered skip bit, and drives the shifter result back toward the bus.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   alu_i, alu_carry_i    : ALU result / carry
//   load_l_i              : capture alu_i into L and alu_carry_i into ALUC0
//   bus_i, load_t_i,
//   t_from_alu_i          : T load strobe and source select (1 = alu_i)
//   sh_op_i               : shifter function
//   dns_i, cy_op_i,
//   skip_code_i           : Nova carry/skip commit, carry base op, skip cond
//   t_o, l_o, aluc0_o,
//   ncarry_o, skip_o      : register contents
//   shifter_o, sh_zero_o,
//   sh_neg_o              : shifter result and its zero/sign flags
module alto_shift_unit
  import alto_shift_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] alu_i,
  input  logic        alu_carry_i,
  input  logic        load_l_i,
  input  logic [15:0] bus_i,
  input  logic        load_t_i,
  input  logic        t_from_alu_i,
  input  logic [2:0]  sh_op_i,
  input  logic        dns_i,
  input  logic [1:0]  cy_op_i,
  input  logic [2:0]  skip_code_i,
  output logic [15:0] t_o,
  output logic [15:0] l_o,
  output logic [15:0] shifter_o,
  output logic        sh_zero_o,
  output logic        sh_neg_o,
  output logic        aluc0_o,
  output logic        ncarry_o,
  output logic        skip_o
);

  logic [15:0] l_q, l_d, t_q, t_d;
  logic        aluc0_q, aluc0_d, ncarry_q, ncarry_d, skip_q, skip_d;
  logic        cy_base, cin, nc, sh_zero, skip_cond;
  logic [15:0] sh_result;

  always_comb begin
    cy_base = ncarry_q;
    unique case (cy_op_e'(cy_op_i))
      CyKeep: cy_base = ncarry_q;
      CyZero: cy_base = 1'b0;
      CyOne:  cy_base = 1'b1;
      CyCmpl: cy_base = ~ncarry_q;
      default: ;
    endcase
  end

  assign cin = cy_base ^ aluc0_q;

  alto_shifter u_shifter (
    .l_i      (l_q),
    .t_i      (t_q),
    .op_i     (sh_op_e'(sh_op_i)),
    .cin_i    (cin),
    .result_o (sh_result),
    .carry_o  (nc)
  );

  assign sh_zero = (sh_result == 16'h0000);

  always_comb begin
    skip_cond = 1'b0;
    unique case (skip_e'(skip_code_i))
      SkipNever:  skip_cond = 1'b0;
      SkipAlways: skip_cond = 1'b1;
      SkipSzc:    skip_cond = ~nc;
      SkipSnc:    skip_cond = nc;
      SkipSzr:    skip_cond = sh_zero;
      SkipSnr:    skip_cond = ~sh_zero;
      SkipSez:    skip_cond = sh_zero | ~nc;
      SkipSbn:    skip_cond = ~sh_zero & nc;
      default: ;
    endcase
  end

  // Next-state uses pre-edge L/T/ALUC0, so simultaneous strobes see old values.
  always_comb begin
    l_d      = l_q;
    aluc0_d  = aluc0_q;
    t_d      = t_q;
    ncarry_d = ncarry_q;
    skip_d   = skip_q;
    if (load_l_i) begin
      l_d     = alu_i;
      aluc0_d = alu_carry_i;
    end
    if (load_t_i) begin
      t_d = t_from_alu_i ? alu_i : bus_i;
    end
    if (dns_i) begin
      ncarry_d = nc;
      skip_d   = skip_cond;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l_q      <= 16'h0000;
      t_q      <= 16'h0000;
      aluc0_q  <= 1'b0;
      ncarry_q <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      l_q      <= l_d;
      t_q      <= t_d;
      aluc0_q  <= aluc0_d;
      ncarry_q <= ncarry_d;
      skip_q   <= skip_d;
    end
  end

  assign t_o       = t_q;
  assign l_o       = l_q;
  assign aluc0_o   = aluc0_q;
  assign ncarry_o  = ncarry_q;
  assign skip_o    = skip_q;
  assign shifter_o = sh_result;
  assign sh_zero_o = sh_zero;
  assign sh_neg_o  = sh_result[15];

endmodule
